// File: rtl/serdesphy_ana_charge_pump_filter.sv
// serdesphy_ana_charge_pump_filter: PI loop filter turning PFD up/down pulses into a saturating VCO control word, with windowed lock detect
module serdesphy_ana_charge_pump_filter #(
    parameter int CTRL_W      = 8,
    parameter int INT_W       = 16,
    parameter int KI_STEP     = 4,
    parameter int KP_STEP     = 32,
    parameter int LOCK_WINDOW = 64,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              up_pulse,
    input  logic              down_pulse,
    output logic [CTRL_W-1:0] ctrl_word,
    output logic              lock,
    output logic              sat_hi,
    output logic              sat_lo
);
    localparam int CW2 = CTRL_W + 2;
    localparam int WW  = $clog2(LOCK_WINDOW);
    localparam int NW  = WW + 2;
    localparam int GW  = $clog2(LOCK_COUNT + 1);
    localparam logic [INT_W-1:0]      ACC_MAX = '1;
    localparam logic [INT_W-1:0]      ACC_RST = INT_W'(1) << (INT_W - 1);
    localparam logic [INT_W-1:0]      KI      = INT_W'(KI_STEP);
    localparam logic signed [CW2-1:0] KP      = CW2'(KP_STEP);
    localparam logic signed [NW-1:0]  LW      = NW'(LOCK_WINDOW);
    localparam logic signed [NW-1:0]  TOL     = NW'(LOCK_TOL);
    localparam logic signed [NW-1:0]  ONE     = 1;
    localparam logic [GW:0]           LC      = (GW + 1)'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
    state_t state, state_next;

    logic [2:0] up_sync, dn_sync;
    logic up_evt, dn_evt, inc, dec, wend, good_win, reached, lock_next;
    logic [INT_W-1:0] acc, acc_next;
    logic signed [CW2-1:0] kick, sum;
    logic [CTRL_W-1:0] ctrl_next;
    logic [WW-1:0] wcnt;
    logic signed [NW-1:0] net, net_tot;
    logic [GW-1:0] good;
    logic [GW:0] good_inc;

    // sync chain per input: [0]=s1, [1]=s2, [2]=s2_d
    assign up_evt = up_sync[1] & ~up_sync[2];
    assign dn_evt = dn_sync[1] & ~dn_sync[2];

    always_comb begin
        inc       = enable & up_evt & ~dn_evt;
        dec       = enable & dn_evt & ~up_evt;
        acc_next  = inc ? (acc > ACC_MAX - KI ? ACC_MAX : acc + KI) :
                    dec ? (acc < KI ? '0 : acc - KI) : acc;
        kick      = inc ? KP : dec ? -KP : '0;
        sum       = $signed({2'b00, acc_next[INT_W-1 -: CTRL_W]}) + kick;
        ctrl_next = sum[CW2-1] ? '0 : |sum[CW2-2:CTRL_W] ? '1 : sum[CTRL_W-1:0];
        net_tot   = inc ? (net >= LW ? net : net + ONE) :
                    dec ? (net <= -LW ? net : net - ONE) : net;
        good_win  = (net_tot <= TOL) && (net_tot >= -TOL);
        wend      = (state != IDLE) && (wcnt == '1);
        good_inc  = {1'b0, good} + 1'b1;
        reached   = good_inc >= LC;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = !enable ? IDLE :
                     (state == IDLE) ? ACQ :
                     (sat_hi | sat_lo) ? ACQ :
                     !wend ? state :
                     !good_win ? ACQ :
                     (state == LOCKED || reached) ? LOCKED : ACQ;
    end

    always_comb begin
        lock_next = state_next == LOCKED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_sync   <= '0;
            dn_sync   <= '0;
            acc       <= ACC_RST;
            ctrl_word <= ACC_RST[INT_W-1 -: CTRL_W];
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            lock      <= 1'b0;
            wcnt      <= '0;
            net       <= '0;
            good      <= '0;
        end else begin
            up_sync   <= {up_sync[1:0], up_pulse};
            dn_sync   <= {dn_sync[1:0], down_pulse};
            acc       <= acc_next;
            ctrl_word <= ctrl_next;
            sat_hi    <= acc_next == ACC_MAX;
            sat_lo    <= acc_next == '0;
            lock      <= lock_next;
            if (state == IDLE || !enable) begin
                wcnt <= '0;
                net  <= '0;
                good <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
                net  <= wend ? '0 : net_tot;
                good <= (sat_hi | sat_lo) ? '0 :
                        !wend ? good :
                        !good_win ? '0 :
                        reached ? good : good_inc[GW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_serdesphy_ana_charge_pump_filter.sv
// tb_serdesphy_ana_charge_pump_filter: scoreboard bench; expected ctrl/sat values queued at pulse launch, checked when due
module tb_serdesphy_ana_charge_pump_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic up = 1'b0;
    logic dn = 1'b0;
    logic [7:0] ctrl_word;
    logic lock, sat_hi, sat_lo;

    serdesphy_ana_charge_pump_filter dut (
        .clk(clk), .rst(rst), .enable(enable), .up_pulse(up), .down_pulse(dn),
        .ctrl_word(ctrl_word), .lock(lock), .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int ctrl; int hi; int lo;} exp_t;
    exp_t sb[$];
    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_acc = 32768;
    int r0;

    task automatic chk(input string tag, input int act, input int exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            x = sb.pop_front();
            chk("sb_ctrl", int'(ctrl_word), x.ctrl);
            chk("sb_sat_hi", int'(sat_hi), x.hi);
            chk("sb_sat_lo", int'(sat_lo), x.lo);
        end
    endtask

    // Model of one launched event: kick visible 3 edges after launch, integral value one edge later
    task automatic ev(input int e);
        int top, k;
        if (!enable) e = 0;
        m_acc = m_acc + 4 * e;
        if (m_acc > 65535) m_acc = 65535;
        if (m_acc < 0) m_acc = 0;
        top = m_acc / 256;
        k = top + 32 * e;
        if (k > 255) k = 255;
        if (k < 0) k = 0;
        sb.push_back('{cyc + 3, k, int'(m_acc == 65535), int'(m_acc == 0)});
        sb.push_back('{cyc + 4, top, int'(m_acc == 65535), int'(m_acc == 0)});
    endtask

    task automatic pulse(input bit u, input bit d, input int hi = 2, input int lo = 2);
        up = u;
        dn = d;
        ev(int'(u) - int'(d));
        repeat (hi) tick();
        up = 1'b0;
        dn = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_reset(input bit en);
        sb.delete();
        rst = 1'b1;
        enable = en;
        tick();
        tick();
        chk("rst_ctrl", int'(ctrl_word), 8'h80);
        chk("rst_lock", int'(lock), 0);
        chk("rst_sat_hi", int'(sat_hi), 0);
        chk("rst_sat_lo", int'(sat_lo), 0);
        chk("rst_acc", int'(dut.acc), 16'h8000);
        rst = 1'b0;
        m_acc = 32768;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset(1'b1);
        r0 = cyc;
        for (int w = 0; w < 3; w++) begin
            wait_to(r0 + 64 * w + 10);
            pulse(1'b1, 1'b0);
            pulse(1'b0, 1'b1);
        end
        wait_to(r0 + 192);
        chk("lock_before", int'(lock), 0);
        tick();
        chk("lock_rise", int'(lock), 1);
        wait_to(r0 + 200);
        repeat (5) pulse(1'b1, 1'b0);
        wait_to(r0 + 256);
        chk("lock_hold", int'(lock), 1);
        tick();
        chk("lock_fall", int'(lock), 0);
        drain();

        do_reset(1'b1);
        pulse(1'b1, 1'b0, 5, 2);
        drain();
        chk("single_acc", int'(dut.acc), 16'h8004);
        chk("single_ctrl", int'(ctrl_word), 8'h80);

        do_reset(1'b1);
        repeat (64) pulse(1'b1, 1'b0);
        drain();
        chk("up64_acc", int'(dut.acc), 16'h8100);
        chk("up64_ctrl", int'(ctrl_word), 8'h81);
        repeat (64) pulse(1'b0, 1'b1);
        drain();
        chk("dn64_ctrl", int'(ctrl_word), 8'h80);
        chk("dn64_acc", int'(dut.acc), 16'h8000);

        pulse(1'b1, 1'b1);
        drain();
        chk("both_acc", int'(dut.acc), 16'h8000);
        chk("both_ctrl", int'(ctrl_word), 8'h80);

        pulse(1'b1, 1'b0);
        drain();
        enable = 1'b0;
        repeat (3) tick();
        chk("dis_lock", int'(lock), 0);
        repeat (3) pulse(1'b1, 1'b0);
        drain();
        chk("dis_acc", int'(dut.acc), 16'h8004);
        chk("dis_ctrl", int'(ctrl_word), 8'h80);
        enable = 1'b1;
        repeat (2) tick();

        repeat (8200) pulse(1'b1, 1'b0);
        drain();
        chk("sat_acc", int'(dut.acc), 16'hFFFF);
        chk("sat_hi", int'(sat_hi), 1);
        chk("sat_ctrl", int'(ctrl_word), 8'hFF);
        chk("sat_lock", int'(lock), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
